// File: rtl/flag_branch_pkg.sv
// flag_branch_pkg: condition codes, flag bit indices, FSM states and condition evaluation
// shared by the flag/branch unit.
package flag_branch_pkg;
   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_CS = 3'b101;
   localparam logic [2:0] COND_CC = 3'b110;
   localparam logic [2:0] COND_NV = 3'b111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
      logic r;
      case (cond)
         COND_AL: r = 1'b1;
         COND_EQ: r = f[FLAG_Z];
         COND_NE: r = !f[FLAG_Z];
         COND_LT: r = f[FLAG_N] ^ f[FLAG_V];
         COND_GE: r = !(f[FLAG_N] ^ f[FLAG_V]);
         COND_CS: r = f[FLAG_C];
         COND_CC: r = !f[FLAG_C];
         default: r = 1'b0;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/flag_branch_unit_if.sv
// flag_branch_unit_if: ALU flag inputs, branch request and branch/flush outputs.
interface flag_branch_unit_if;
   logic [31:0] alu_result;
   logic        alu_carry;
   logic        alu_ovf;
   logic        flag_we;
   logic        br_valid;
   logic        br_ready;
   logic [2:0]  br_cond;
   logic [31:0] br_target;
   logic        br_taken;
   logic [31:0] br_pc;
   logic        flush;
   logic [3:0]  flags;
   logic [15:0] taken_cnt;

   modport master (
      output alu_result, alu_carry, alu_ovf, flag_we, br_valid, br_cond, br_target,
      input  br_ready, br_taken, br_pc, flush, flags, taken_cnt
   );

   modport slave (
      input  alu_result, alu_carry, alu_ovf, flag_we, br_valid, br_cond, br_target,
      output br_ready, br_taken, br_pc, flush, flags, taken_cnt
   );
endinterface

// File: rtl/zero_detect32.sv
// zero_detect32: 32-bit zero detect as a pairwise OR reduction tree and one final inversion.
module zero_detect32 (
   input  logic [31:0] i_data,
   output logic        o_zero
);
   logic [15:0] w_l1;
   logic [7:0]  w_l2;
   logic [3:0]  w_l3;
   logic [1:0]  w_l4;
   logic        w_any;

   assign w_l1   = i_data[31:16] | i_data[15:0];
   assign w_l2   = w_l1[15:8] | w_l1[7:0];
   assign w_l3   = w_l2[7:4] | w_l2[3:0];
   assign w_l4   = w_l3[3:2] | w_l3[1:0];
   assign w_any  = w_l4[1] | w_l4[0];
   assign o_zero = ~w_any;
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: NZCV flag register, conditional branch resolve with one-cycle flush FSM.
// Define FLAG_BYPASS_EN to evaluate conditions on flags being written in the same cycle.
module flag_branch_unit
   import flag_branch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   flag_branch_unit_if.slave  bus
);
   state_t      r_state, w_next;
   logic [3:0]  r_flags, w_new_flags, w_eval_flags;
   logic        w_zero, w_hit, r_taken;
   logic [31:0] r_pc;
   logic [15:0] r_cnt;

   zero_detect32 u_zero (
      .i_data (bus.alu_result),
      .o_zero (w_zero)
   );

   assign w_new_flags = {bus.alu_result[31], w_zero, bus.alu_carry, bus.alu_ovf};

`ifdef FLAG_BYPASS_EN
   assign w_eval_flags = bus.flag_we ? w_new_flags : r_flags;
`else
   assign w_eval_flags = r_flags;
`endif

   // Requests arriving during FLUSH are dropped, not queued
   assign w_hit = bus.br_valid && (r_state == ST_IDLE) && cond_met(bus.br_cond, w_eval_flags);

   always_comb begin
      w_next       = ST_IDLE;
      bus.br_ready = 1'b0;
      bus.flush    = 1'b0;
      if (r_state == ST_IDLE) begin
         bus.br_ready = 1'b1;
         w_next       = w_hit ? ST_FLUSH : ST_IDLE;
      end else begin
         bus.flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_flags <= 4'b0000;
         r_taken <= 1'b0;
         r_pc    <= 32'h0;
         r_cnt   <= 16'h0;
      end else begin
         r_state <= w_next;
         r_flags <= bus.flag_we ? w_new_flags : r_flags;
         r_taken <= w_hit;
         r_pc    <= w_hit ? bus.br_target : r_pc;
         r_cnt   <= r_cnt + {15'b0, w_hit && (r_cnt != 16'hFFFF)};
      end
   end

   assign bus.flags     = r_flags;
   assign bus.br_taken  = r_taken;
   assign bus.br_pc     = r_pc;
   assign bus.taken_cnt = r_cnt;
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed and randomized checks of flag_branch_unit against a
// cycle-level reference model of the flag/branch rules.
module tb_flag_branch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   flag_branch_unit_if bus ();
   flag_branch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef FLAG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0]  m_flags;
   logic        m_busy, m_taken;
   logic [31:0] m_pc;
   logic [15:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit cond_true(input logic [2:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return n != v;
         3'd4: return n == v;
         3'd5: return cy;
         3'd6: return !cy;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_flags = 4'h0; m_busy = 1'b0; m_taken = 1'b0; m_pc = 32'h0; m_cnt = 16'h0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".flags"}, {28'h0, bus.flags}, {28'h0, m_flags});
      check({tag, ".taken"}, {31'h0, bus.br_taken}, {31'h0, m_taken});
      check({tag, ".pc"}, bus.br_pc, m_pc);
      check({tag, ".flush"}, {31'h0, bus.flush}, {31'h0, m_busy});
      check({tag, ".ready"}, {31'h0, bus.br_ready}, {31'h0, !m_busy});
      check({tag, ".cnt"}, {16'h0, bus.taken_cnt}, {16'h0, m_cnt});
   endtask

   task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] t,
                        input logic we, input logic [31:0] res, input logic cy, input logic ov);
      bus.br_valid = v; bus.br_cond = c; bus.br_target = t;
      bus.flag_we = we; bus.alu_result = res; bus.alu_carry = cy; bus.alu_ovf = ov;
   endtask

   task automatic idle();
      drive(1'b0, 3'd7, 32'h0, 1'b0, 32'h1, 1'b0, 1'b0);
   endtask

   // Advance one clock: predict from the applied inputs, then compare after the edge
   task automatic tick(input string tag);
      logic [3:0] nf, ef;
      bit acc;
      nf  = {bus.alu_result[31], bus.alu_result == 32'h0, bus.alu_carry, bus.alu_ovf};
      ef  = (BYP && bus.flag_we) ? nf : m_flags;
      acc = !m_busy && bus.br_valid && cond_true(bus.br_cond, ef);
      @(posedge clk);
      #1;
      m_taken = acc;
      m_busy  = acc;
      if (acc) m_pc = bus.br_target;
      if (acc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      if (bus.flag_we) m_flags = nf;
      check_all(tag);
   endtask

   logic [15:0] c0;
   logic [31:0] res;

   initial begin
      idle();
      rst_n = 1'b0;
      #12;
      model_reset();
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all("rst_rel");
      tick("idle");

      drive(1'b0, 3'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      tick("eq_setz");
      drive(1'b1, 3'd1, 32'h100, 1'b0, 32'h5, 1'b0, 1'b0);
      tick("eq_br");
      check("eq_pc", bus.br_pc, 32'h100);
      check("eq_flush", {31'h0, bus.flush}, 32'h1);
      idle();
      tick("eq_after");
      check("eq_cnt", {16'h0, bus.taken_cnt}, 32'h1);

      drive(1'b0, 3'd0, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
      tick("lt_setn");
      drive(1'b1, 3'd3, 32'h200, 1'b0, 32'h1, 1'b0, 1'b0);
      tick("lt_br");
      check("lt_taken", {31'h0, bus.br_taken}, 32'h1);
      idle();
      tick("lt_after");
      drive(1'b1, 3'd4, 32'h300, 1'b0, 32'h1, 1'b0, 1'b0);
      tick("ge_br");
      check("ge_flush", {31'h0, bus.flush}, 32'h0);
      check("ge_pc", bus.br_pc, 32'h200);

      drive(1'b0, 3'd0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0);
      tick("byp_clrz");
      drive(1'b1, 3'd1, 32'h400, 1'b1, 32'h0, 1'b0, 1'b0);
      tick("byp_br");
      check("byp_taken", {31'h0, bus.br_taken}, {31'h0, BYP});
      idle();
      tick("byp_after");
      tick("byp_idle");

      c0 = m_cnt;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 3'd0, 32'h500 + i, 1'b0, 32'h1, 1'b0, 1'b0);
         tick("b2b");
      end
      idle();
      check("b2b_cnt", {16'h0, bus.taken_cnt}, {16'h0, c0 + 16'd2});
      tick("b2b_after");

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 2))
            0: res = 32'h0;
            1: res = 32'h8000_0000 | $urandom;
            default: res = $urandom;
         endcase
         drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom,
               1'($urandom), res, 1'($urandom), 1'($urandom));
         tick("rnd");
      end
      idle();
      tick("rnd_end");
      tick("rnd_idle");

      @(negedge clk);
      force dut.r_cnt = 16'hFFFE;
      #1;
      release dut.r_cnt;
      m_cnt = 16'hFFFE;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'd0, 32'hA000 + i, 1'b0, 32'h1, 1'b0, 1'b0);
         tick("sat_br");
         idle();
         tick("sat_after");
         check("sat_cnt", {16'h0, bus.taken_cnt}, 32'hFFFF);
      end

      drive(1'b1, 3'd0, 32'hB000, 1'b0, 32'h1, 1'b0, 1'b0);
      tick("abort_br");
      idle();
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_flush", {31'h0, bus.flush}, 32'h0);
      check("abort_taken", {31'h0, bus.br_taken}, 32'h0);
      model_reset();
      check_all("abort_rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick("abort_rel");
      check("abort_nopulse", {31'h0, bus.br_taken}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; clock and reset are the only timing inputs.
REQ-002 SHALL expose: clk  input  1  rising-edge clock.
REQ-003 SHALL expose: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL expose: alu_result  input  32  ALU result of current instruction.
REQ-005 SHALL expose: alu_carry, alu_ovf  input  1 each  ALU carry-out, signed overflow.
REQ-006 SHALL expose: flag_we  input  1  capture flags this cycle.
REQ-007 SHALL expose: br_valid  input  1  branch request present; br_ready  output  1  unit can accept.
REQ-008 SHALL expose: br_cond  input  3  condition code; br_target  input  32  branch destination.
REQ-009 SHALL expose: br_taken  output  1  registered taken pulse; br_pc  output  32  registered target.
REQ-010 SHALL expose: flush  output  1  squash fetch/decode; flags  output  4  {N,Z,C,V} register.
REQ-011 SHALL expose: taken_cnt  output  16  count of taken branches.

Function
REQ-012 SHALL compute zero = NOR of all 32 alu_result bits; negative = alu_result[31].
REQ-013 SHALL load flags <= {neg, zero, alu_carry, alu_ovf} on rising edge when flag_we=1; hold otherwise.
REQ-014 SHALL decode br_cond: 000 always, 001 EQ(Z), 010 NE(!Z), 011 LT(N^V), 100 GE(!(N^V)), 101 CS(C), 110 CC(!C), 111 never.
REQ-015 SHALL accept a branch when br_valid && br_ready; acceptance with a non-taken condition has no effect except that cycle's evaluation.
REQ-016 SHALL, on accepted taken branch, assert br_taken for exactly one cycle starting the next cycle, with br_pc = br_target sampled at acceptance.
REQ-017 SHALL implement FSM IDLE/FLUSH: IDLE->FLUSH on accepted taken branch; FLUSH->IDLE unconditionally after one cycle.
REQ-018 SHALL drive flush=1 and br_ready=0 only in FLUSH; br_ready=1 in IDLE.
REQ-019 SHALL ignore br_valid in FLUSH; no request is queued.
REQ-020 SHALL increment taken_cnt by 1 per accepted taken branch, saturating at 16'hFFFF (no wrap).
REQ-021 SHALL allow flag_we in the same cycle as an accepted branch; flag update occurs regardless of FSM state.
REQ-022 br_pc SHALL hold its last value when no taken branch is accepted.

Reset
REQ-023 SHALL on rst_n=0, asynchronously: FSM=IDLE, flags=4'b0000, br_taken=0, br_pc=0, flush=0, taken_cnt=0; br_ready=1 after release.
REQ-024 Reset asserted during FLUSH SHALL abort the flush immediately; no br_taken pulse follows release.

Configuration
REQ-025 Macro FLAG_BYPASS_EN SHALL select flag source for condition evaluation.
REQ-026 With FLAG_BYPASS_EN defined: when flag_we=1 in the acceptance cycle, the condition SHALL use the new flags being written; otherwise registered flags.
REQ-027 Without FLAG_BYPASS_EN: the condition SHALL always use the registered flags (value before this edge).

Structure
REQ-028 Condition-code constants (COND_AL..COND_NV), flag bit indices, and FSM state encodings SHALL live in shared package flag_branch_pkg.
REQ-029 The 32-bit zero detect SHALL be a sub-module zero_detect32, built as an OR-gate reduction tree followed by one inversion.

Verification
REQ-030 Reset then idle: after rst_n rises, flags=0, taken_cnt=0, br_ready=1, flush=0.
REQ-031 alu_result=0, flag_we=1; next cycle br_valid=1, br_cond=001, br_target=32'h0000_0100 -> next cycle br_taken=1, br_pc=32'h100, flush=1, br_ready=0; cycle after: all deasserted, taken_cnt=1.
REQ-032 alu_result=32'h8000_0000, alu_ovf=0, flag_we=1; then br_cond=011 -> taken; with br_cond=100 -> not taken, no flush.
REQ-033 Same-cycle flag_we (alu_result=0) and br_cond=001 with prior Z=0 -> taken only if FLAG_BYPASS_EN defined; not taken otherwise.
REQ-034 Back-to-back br_valid=1, br_cond=000 for 4 cycles -> taken on cycles 1 and 3 only; br_ready low on 2 and 4; taken_cnt=2.
REQ-035 Preload taken_cnt to 16'hFFFE via 2 forced/initialised taken branches path; two more taken -> taken_cnt stays 16'hFFFF; assert rst_n=0 during FLUSH -> flush drops immediately.
